shf_seq: RTL and testbench

Sequencer and two-port arbiter for the barrel-shifter datapath (`shifter`). It accepts shift requests from two requesters, arbitrates between them round-robin, and drives the shifter's enable, class and operand inputs. It captures the shifter result and flags, and returns them with a requester tag. It also implements a two-pass NORM operation (leading-zero count, then shift) and keeps a sticky overflow flag for the program sequencer.

---
 rtl/shf_seq.sv | 207 ++++++++++++++++++++
 tb/tb_shf_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shf_seq.sv
// Sequencer and round-robin two-port arbiter for the barrel shifter.
// Issues single-pass ops and the two-pass NORM, then returns a tagged response.
module shf_seq #(
    parameter int DATASIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [2:0]          req0_op,
    input  logic [DATASIZE-1:0] req0_x,
    input  logic [DATASIZE-1:0] req0_y,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [2:0]          req1_op,
    input  logic [DATASIZE-1:0] req1_x,
    input  logic [DATASIZE-1:0] req1_y,
    output logic                shf_en,
    output logic [1:0]          shf_cls,
    output logic [DATASIZE-1:0] shf_x,
    output logic [DATASIZE-1:0] shf_y,
    input  logic [DATASIZE-1:0] shf_dt,
    input  logic                shf_sv,
    input  logic                shf_sz,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [DATASIZE-1:0] rsp_dt,
    output logic                rsp_sv,
    output logic                rsp_sz,
    output logic                rsp_err,
    output logic                sticky_sv,
    input  logic                clr_sticky,
    output logic                busy
);
    typedef enum logic [2:0] {
        IDLE, ISSUE, CAPT, ISSUE2, CAPT2, RESP
    } state_t;

    localparam logic [2:0] OP_NORM = 3'b100;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [2:0]          op_q, op_d;
    logic [DATASIZE-1:0] x_q, x_d;
    logic                id_q, id_d;
    logic                shf_en_q, shf_en_d;
    logic [1:0]          shf_cls_q, shf_cls_d;
    logic [DATASIZE-1:0] shf_x_q, shf_x_d;
    logic [DATASIZE-1:0] shf_y_q, shf_y_d;
    logic                rsp_id_q, rsp_id_d;
    logic [DATASIZE-1:0] rsp_dt_q, rsp_dt_d;
    logic                rsp_sv_q, rsp_sv_d;
    logic                rsp_sz_q, rsp_sz_d;
    logic                rsp_err_q, rsp_err_d;
    logic                sticky_q, sticky_d;

    logic                gnt0, gnt1, accept, a_rsvd;
    logic [2:0]          a_op;
    logic [DATASIZE-1:0] a_x, a_y;
    logic [4:0]          cnt_m1;

    // On a tie the requester that was not granted last wins.
    assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
    assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

    assign req0_ready = (state_q == IDLE) & ~rst & gnt0;
    assign req1_ready = (state_q == IDLE) & ~rst & gnt1;
    assign accept     = req0_ready | req1_ready;

    assign a_op   = gnt1 ? req1_op : req0_op;
    assign a_x    = gnt1 ? req1_x : req0_x;
    assign a_y    = gnt1 ? req1_y : req0_y;
    assign a_rsvd = a_op[2] & (a_op[1:0] != 2'b00);
    assign cnt_m1 = shf_dt[4:0] - 5'd1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        x_d          = x_q;
        id_d         = id_q;
        shf_en_d     = 1'b0;
        shf_cls_d    = shf_cls_q;
        shf_x_d      = shf_x_q;
        shf_y_d      = shf_y_q;
        rsp_id_d     = rsp_id_q;
        rsp_dt_d     = rsp_dt_q;
        rsp_sv_d     = rsp_sv_q;
        rsp_sz_d     = rsp_sz_q;
        rsp_err_d    = rsp_err_q;
        sticky_d     = sticky_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d         = a_op;
                    x_d          = a_x;
                    id_d         = gnt1;
                    last_grant_d = gnt1;
                    if (a_rsvd) begin
                        state_d   = RESP;
                        rsp_id_d  = gnt1;
                        rsp_dt_d  = '0;
                        rsp_sv_d  = 1'b0;
                        rsp_sz_d  = 1'b0;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d   = ISSUE;
                        shf_en_d  = 1'b1;
                        shf_cls_d = (a_op == OP_NORM) ? 2'b10 : a_op[1:0];
                        shf_x_d   = a_x;
                        shf_y_d   = a_y;
                    end
                end
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                if (op_q == OP_NORM) begin
                    // Second pass shifts left by (lz - 1) to keep bit 15 clear.
                    state_d   = ISSUE2;
                    shf_en_d  = 1'b1;
                    shf_cls_d = 2'b00;
                    shf_x_d   = x_q;
                    if (shf_dt[4:0] == 5'd0) begin
                        shf_y_d = '0;
                    end else begin
                        shf_y_d = {{(DATASIZE-5){1'b0}}, cnt_m1};
                    end
                end else begin
                    state_d   = RESP;
                    rsp_id_d  = id_q;
                    rsp_dt_d  = shf_dt;
                    rsp_sv_d  = shf_sv;
                    rsp_sz_d  = shf_sz;
                    rsp_err_d = 1'b0;
                end
            end
            ISSUE2: state_d = CAPT2;
            CAPT2: begin
                state_d   = RESP;
                rsp_id_d  = id_q;
                rsp_dt_d  = shf_dt;
                rsp_sv_d  = shf_sv;
                rsp_sz_d  = shf_sz;
                rsp_err_d = 1'b0;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_q == RESP) && rsp_sv_q) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            x_q          <= '0;
            id_q         <= 1'b0;
            shf_en_q     <= 1'b0;
            shf_cls_q    <= '0;
            shf_x_q      <= '0;
            shf_y_q      <= '0;
            rsp_id_q     <= 1'b0;
            rsp_dt_q     <= '0;
            rsp_sv_q     <= 1'b0;
            rsp_sz_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            x_q          <= x_d;
            id_q         <= id_d;
            shf_en_q     <= shf_en_d;
            shf_cls_q    <= shf_cls_d;
            shf_x_q      <= shf_x_d;
            shf_y_q      <= shf_y_d;
            rsp_id_q     <= rsp_id_d;
            rsp_dt_q     <= rsp_dt_d;
            rsp_sv_q     <= rsp_sv_d;
            rsp_sz_q     <= rsp_sz_d;
            rsp_err_q    <= rsp_err_d;
            sticky_q     <= sticky_d;
        end
    end

    assign shf_en    = shf_en_q;
    assign shf_cls   = shf_cls_q;
    assign shf_x     = shf_x_q;
    assign shf_y     = shf_y_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_dt    = rsp_dt_q;
    assign rsp_sv    = rsp_sv_q;
    assign rsp_sz    = rsp_sz_q;
    assign rsp_err   = rsp_err_q;
    assign sticky_sv = sticky_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shf_seq.sv
// Scoreboard bench for shf_seq with a behavioural shifter and reference model.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_shf_seq;
    localparam int W = 16;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] x;
        logic [15:0] y;
    } req_t;

    typedef struct {
        logic        id;
        logic        err;
        logic [15:0] dt;
        logic        sv;
        logic        sz;
        int          ens;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [2:0]    req0_op = '0, req1_op = '0;
    logic [W-1:0]  req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic          shf_en;
    logic [1:0]    shf_cls;
    logic [W-1:0]  shf_x, shf_y;
    logic [W-1:0]  shf_dt = '0;
    logic          shf_sv = 1'b0, shf_sz = 1'b0;
    logic          rsp_valid, rsp_id, rsp_sv, rsp_sz, rsp_err;
    logic [W-1:0]  rsp_dt;
    logic          sticky_sv, busy;
    logic          clr_sticky = 1'b0;

    int   n_chk = 0, n_pass = 0;
    int   cyc = 0;
    bit   chk_en = 0;
    bit   lg = 1;
    int   free_cyc = 0;
    bit   acc0 = 0, acc1 = 0;
    bit   s_model = 0, sv_now = 0;
    int   en_cnt = 0;
    req_t cur0, cur1;
    req_t pend0[$], pend1[$];
    exp_t sb[$];

    shf_seq #(.DATASIZE(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
        .shf_en(shf_en), .shf_cls(shf_cls), .shf_x(shf_x), .shf_y(shf_y),
        .shf_dt(shf_dt), .shf_sv(shf_sv), .shf_sz(shf_sz),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_dt(rsp_dt),
        .rsp_sv(rsp_sv), .rsp_sz(rsp_sz), .rsp_err(rsp_err),
        .sticky_sv(sticky_sv), .clr_sticky(clr_sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shifter behaviour: {dt, sv, sz}, registered one cycle after enable.
    function automatic logic [17:0] shf_fn(input logic [1:0] c,
                                           input logic [15:0] x,
                                           input logic [15:0] y);
        logic [15:0] r, b;
        logic v;
        int n, k;
        r = '0; b = '0; v = 1'b0; k = 0;
        n = int'($signed(y));
        case (c)
            2'd0: begin
                if (n >= 0) begin
                    if (n > 15) begin
                        r = '0;
                        v = (x != 16'h0);
                    end else begin
                        r = x << n;
                        b = 16'($signed(r) >>> n);
                        v = (b != x);
                    end
                end else begin
                    k = (-n > 15) ? 15 : -n;
                    r = 16'($signed(x) >>> k);
                end
            end
            2'd1: begin
                k = int'(y[3:0]);
                r = (k == 0) ? x : ((x << k) | (x >> (16 - k)));
            end
            2'd2: begin
                while (k < 16 && !x[15-k]) k++;
                r = 16'(k);
                v = (x == 16'h0000);
            end
            default: begin
                while (k < 16 && x[15-k]) k++;
                r = 16'(k);
                v = (x == 16'hFFFF);
            end
        endcase
        return {r, v, (r == 16'h0)};
    endfunction

    always @(posedge clk) begin
        if (shf_en) {shf_dt, shf_sv, shf_sz} <= shf_fn(shf_cls, shf_x, shf_y);
    end

    // Expected response for one accepted request.
    function automatic exp_t model(input req_t r, input logic id);
        exp_t e;
        logic [15:0] v;
        e.id = id; e.err = 0; e.dt = '0; e.sv = 0; e.sz = 0;
        e.ens = 1; e.cyc = 0;
        if (r.op > 3'd4) begin
            e.err = 1;
            e.ens = 0;
        end else if (r.op == 3'd4) begin
            e.ens = 2;
            if (r.x == 16'h0) begin
                e.sz = 1;
            end else begin
                v = r.x;
                if (!v[15]) while (!v[14]) v = v << 1;
                e.dt = v;
            end
        end else begin
            {e.dt, e.sv, e.sz} = shf_fn(r.op[1:0], r.x, r.y);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h t=%0t",
                      nm, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (rst) s_model <= 0;
        else if (sv_now) s_model <= 1;
        else if (clr_sticky) s_model <= 0;
    end

    // Arbitration model: checks readiness and pushes expectations.
    bit   d_idle, d_e0, d_e1;
    req_t d_r;
    exp_t d_e;
    int   d_off;
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            d_idle = (cyc >= free_cyc);
            d_e0 = d_idle && req0_valid && (!req1_valid || lg);
            d_e1 = d_idle && req1_valid && (!req0_valid || !lg);
            chk("req0_ready", 32'(req0_ready), 32'(d_e0));
            chk("req1_ready", 32'(req1_ready), 32'(d_e1));
            chk("busy", 32'(busy), 32'(!d_idle));
            if (d_e0 || d_e1) begin
                d_r = d_e0 ? cur0 : cur1;
                d_e = model(d_r, d_e1);
                d_off = (d_r.op > 3'd4) ? 0 : ((d_r.op == 3'd4) ? 4 : 2);
                d_e.cyc = cyc + 1 + d_off;
                sb.push_back(d_e);
                free_cyc = d_e.cyc + 1;
                lg = d_e1;
                acc0 = d_e0;
                acc1 = d_e1;
            end
        end
    end

    exp_t m_e;
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("sticky_sv", 32'(sticky_sv), 32'(s_model));
            sv_now = 0;
            if (shf_en) en_cnt++;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 32'(rsp_valid), 32'(0));
                end else begin
                    m_e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(m_e.id));
                    chk("rsp_dt", 32'(rsp_dt), 32'(m_e.dt));
                    chk("rsp_sv", 32'(rsp_sv), 32'(m_e.sv));
                    chk("rsp_sz", 32'(rsp_sz), 32'(m_e.sz));
                    chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
                    chk("rsp_cycle", 32'(cyc), 32'(m_e.cyc));
                    chk("shf_en_count", 32'(en_cnt), 32'(m_e.ens));
                    en_cnt = 0;
                    sv_now = m_e.sv;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (acc0) begin req0_valid = 0; acc0 = 0; end
        if (acc1) begin req1_valid = 0; acc1 = 0; end
        if (!req0_valid && pend0.size() > 0) begin
            cur0 = pend0.pop_front();
            req0_valid = 1;
            req0_op = cur0.op; req0_x = cur0.x; req0_y = cur0.y;
        end
        if (!req1_valid && pend1.size() > 0) begin
            cur1 = pend1.pop_front();
            req1_valid = 1;
            req1_op = cur1.op; req1_x = cur1.x; req1_y = cur1.y;
        end
        clr_sticky = ($urandom_range(0, 3) == 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || req0_valid ||
                req1_valid || sb.size() > 0) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            n_chk++;
            $display("FAIL drain_timeout actual=%0d expected=<3000", n);
        end
        step();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req0_ready"}, 32'(req0_ready), 0);
        chk({tag, "_req1_ready"}, 32'(req1_ready), 0);
        chk({tag, "_shf_en"}, 32'(shf_en), 0);
        chk({tag, "_shf_cls"}, 32'(shf_cls), 0);
        chk({tag, "_shf_x"}, 32'(shf_x), 0);
        chk({tag, "_shf_y"}, 32'(shf_y), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
        chk({tag, "_rsp_dt"}, 32'(rsp_dt), 0);
        chk({tag, "_rsp_flags"}, 32'({rsp_sv, rsp_sz, rsp_err}), 0);
        chk({tag, "_sticky"}, 32'(sticky_sv), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    function automatic req_t mk(input logic [2:0] op, input logic [15:0] x,
                                input logic [15:0] y);
        req_t r;
        r.op = op; r.x = x; r.y = y;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        int p, a;
        p = int'($urandom_range(0, 99));
        if (p < 30) r.op = 3'd0;
        else if (p < 50) r.op = 3'd1;
        else if (p < 62) r.op = 3'd2;
        else if (p < 72) r.op = 3'd3;
        else if (p < 92) r.op = 3'd4;
        else r.op = 3'($urandom_range(5, 7));
        r.x = 16'($urandom) >> $urandom_range(0, 16);
        if ($urandom_range(0, 3) == 0) r.x = ~r.x;
        a = int'($urandom_range(0, 40)) - 20;
        r.y = 16'(a);
        if ($urandom_range(0, 9) == 0) r.y = 16'($urandom);
        return r;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1;
        req0_valid = 1;
        req1_valid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 0;
        req0_valid = 0;
        req1_valid = 0;
        chk_en = 1;

        pend0.push_back(mk(3'd0, 16'hF000, 16'hFFFC));
        drain();
        pend1.push_back(mk(3'd1, 16'hC000, 16'h0002));
        pend1.push_back(mk(3'd2, 16'h0000, 16'h0000));
        drain();
        pend0.push_back(mk(3'd4, 16'h00F0, 16'h0000));
        pend0.push_back(mk(3'd4, 16'h0000, 16'h0000));
        pend0.push_back(mk(3'd4, 16'h8001, 16'h0000));
        drain();
        for (int i = 0; i < 2; i++) begin
            pend0.push_back(mk(3'd0, 16'($urandom), 16'h0003));
            pend1.push_back(mk(3'd0, 16'($urandom), 16'hFFFE));
        end
        drain();
        pend1.push_back(mk(3'd6, 16'h1234, 16'h0001));
        drain();

        // Reset during CAPT2 of a NORM: response must be dropped.
        pend0.push_back(mk(3'd4, 16'h0F00, 16'h0000));
        n = 0;
        while (sb.size() == 0 && n < 50) begin
            step();
            n++;
        end
        repeat (3) step();
        rst = 1;
        step();
        rst = 0;
        sb.delete();
        free_cyc = 0;
        lg = 1;
        en_cnt = 0;
        @(negedge clk);
        check_zero("midrst");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) pend0.push_back(rnd_req());
            else pend1.push_back(rnd_req());
        end
        drain();
        repeat (3) step();
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
